// File: rtl/zx_timing_pkg.sv
// Spectrum 48K raster and ULA contention timing shared by the clock-enable block.
package zx_timing_pkg;

    localparam int H_TOTAL     = 448;
    localparam int V_TOTAL     = 312;
    localparam int CONT_VSTART = 64;
    localparam int CONT_VLINES = 192;
    localparam int CONT_HEND   = 256;
    localparam int IRQ_LINE    = 248;
    localparam int IRQ_LEN     = 64;

    localparam int HC_W      = 9;
    localparam int VC_W      = 9;
    localparam int IRQ_CNT_W = $clog2(IRQ_LEN);

    // Lines above the window wrap to large unsigned values, so one compare covers both ends.
    function automatic logic in_cont_window(
        input logic [HC_W-1:0] hc,
        input logic [VC_W-1:0] vc,
        input int              hend
    );
        logic [VC_W-1:0] dv;
        dv = vc - VC_W'(CONT_VSTART);
        return (dv < VC_W'(CONT_VLINES)) && (hc < HC_W'(hend));
    endfunction

endpackage

// File: rtl/clock_enables_raster_counter.sv
// Horizontal/vertical raster counters; both wrap together at the end of a frame.
module raster_counter
    import zx_timing_pkg::*;
#(
    parameter int LINE_CLKS = H_TOTAL
) (
    input  logic            clock,
    input  logic            reset,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc
);

    logic line_end;
    logic frame_end;

    assign line_end  = (hc == HC_W'(LINE_CLKS - 1));
    assign frame_end = line_end && (vc == VC_W'(V_TOTAL - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (line_end) begin
            hc <= '0;
            vc <= frame_end ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

endmodule

// File: rtl/clock_enables.sv
// Divides clock70 into pixel/CPU enables, stalls CPU rising edges for ULA contention
// and generates the 50 Hz /INT.
module clock_enables
    import zx_timing_pkg::*;
#(
    parameter int LINE_CLKS = H_TOTAL,
    parameter int HWIN_END  = CONT_HEND
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            contend,
    output logic            ce_pix,
    output logic            ce_cpu_p,
    output logic            ce_cpu_n,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            int_n
);

    logic                 cpu_lvl;
    logic                 phase;
    logic [2:0]           t_lo;
    logic                 win;
    logic                 stall;
    logic                 rise;
    logic                 fall;
    logic                 irq_hit;
    logic [IRQ_CNT_W-1:0] irq_cnt;

    raster_counter #(.LINE_CLKS(LINE_CLKS)) u_raster (
        .clock (clock),
        .reset (reset),
        .hc    (hc),
        .vc    (vc)
    );

    assign phase = hc[0];
    assign t_lo  = hc[3:1];
    assign win   = in_cont_window(hc, vc, HWIN_END);

    // Stall only T-states 0..5 of each 8; that gives the 6,5,4,3,2,1,0,0 delay pattern.
    assign stall   = win && contend && (t_lo <= 3'd5);
    assign rise    = !phase && !cpu_lvl && !stall;
    assign fall    = phase && cpu_lvl;
    assign irq_hit = (vc == VC_W'(IRQ_LINE)) && (hc == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ce_pix   <= 1'b0;
            ce_cpu_p <= 1'b0;
            ce_cpu_n <= 1'b0;
            cpu_lvl  <= 1'b0;
        end else begin
            ce_pix   <= 1'b1;
            ce_cpu_p <= rise;
            ce_cpu_n <= fall;
            if (rise)
                cpu_lvl <= 1'b1;
            else if (fall)
                cpu_lvl <= 1'b0;
        end
    end

    // int_n is low from the cycle after the trigger for exactly IRQ_LEN cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_n   <= 1'b1;
            irq_cnt <= '0;
        end else if (irq_hit && int_n) begin
            int_n   <= 1'b0;
            irq_cnt <= IRQ_CNT_W'(IRQ_LEN - 1);
        end else if (!int_n) begin
            if (irq_cnt == '0)
                int_n <= 1'b1;
            else
                irq_cnt <= irq_cnt - 1'b1;
        end
    end

endmodule
